// File: rtl/ahb_multi_master_arbiter.sv
// ahb_multi_master_arbiter
//   N-master AHB-lite arbiter and bus mux in front of a single slave port.
//   The address-phase owner (owner_q) and the data-phase owner (downer_q) are
//   tracked separately. Ownership can therefore move on any accepted transfer
//   while the previous owner's last data phase is still completing.
//   Arbitration is fixed priority (ARB_MODE=0) or round robin (ARB_MODE=1).
//   It also supports a per-owner lock and a hold limit (MAX_HOLD).
// Ports
//   clk_i, resetn_i            clock, async active-low reset
//   req_i, lock_i              per-master request / lock
//   grant_o, stall_o, owner_o  registered one-hot grant, stall, owner index
//   m_*_i / m_*_o              flattened master-side AHB signals
//   haddr_o..hwdata_o          muxed slave-side request
//   hrdata_i, hready_i, hresp_i  slave response
module ahb_multi_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int MAX_HOLD    = 16
) (
    input  logic                               clk_i,
    input  logic                               resetn_i,
    input  logic [NUM_MASTERS-1:0]             req_i,
    input  logic [NUM_MASTERS-1:0]             lock_i,
    output logic [NUM_MASTERS-1:0]             grant_o,
    output logic [NUM_MASTERS-1:0]             stall_o,
    output logic [$clog2(NUM_MASTERS)-1:0]     owner_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_haddr_i,
    input  logic [NUM_MASTERS*2-1:0]           m_htrans_i,
    input  logic [NUM_MASTERS-1:0]             m_hwrite_i,
    input  logic [NUM_MASTERS*3-1:0]           m_hsize_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_hwdata_i,
    output logic [DATA_WIDTH-1:0]              m_hrdata_o,
    output logic [NUM_MASTERS-1:0]             m_hready_o,
    output logic [NUM_MASTERS*2-1:0]           m_hresp_o,
    output logic [ADDR_WIDTH-1:0]              haddr_o,
    output logic [1:0]                         htrans_o,
    output logic                               hwrite_o,
    output logic [2:0]                         hsize_o,
    output logic [DATA_WIDTH-1:0]              hwdata_o,
    input  logic [DATA_WIDTH-1:0]              hrdata_i,
    input  logic                               hready_i,
    input  logic [1:0]                         hresp_i
);
    localparam int OW = $clog2(NUM_MASTERS);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   downer_q, downer_d;
    logic            dvalid_q, dvalid_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic                   owned;
    logic                   others_req;
    logic                   hold_hit;
    logic                   rearb;
    logic [NUM_MASTERS-1:0] cand;
    logic [OW-1:0]          win;
    logic                   found;

    assign owned = (state_q == ST_OWNED);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            downer_q <= '0;
            dvalid_q <= 1'b0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            downer_q <= downer_d;
            dvalid_q <= dvalid_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // Winner search over the candidate mask.
    always_comb begin
        others_req = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++)
            if (req_i[i] && !(owned && owner_q == OW'(i))) others_req = 1'b1;

        hold_hit = (MAX_HOLD != 0) && owned && (hold_q == HOLD_LIM) &&
                   others_req && !lock_i[owner_q];
        rearb = !owned || (!req_i[owner_q] && !lock_i[owner_q]) || hold_hit;

        // An owner hitting the hold limit steps aside; others_req guarantees
        // someone else is left to pick.
        cand = req_i;
        if (hold_hit) cand[owner_q] = 1'b0;

        win   = '0;
        found = 1'b0;
        if (ARB_MODE == 1) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                int idx;
                idx = (int'(rr_ptr_q) + k) % NUM_MASTERS;
                if (!found && cand[idx]) begin
                    win   = OW'(idx);
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win   = OW'(i);
                    found = 1'b1;
                end
            end
        end
    end

    // Next-state: nothing moves unless the slave accepts (hready_i = 1).
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        downer_d = downer_q;
        dvalid_d = dvalid_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        if (hready_i) begin
            dvalid_d = owned && (htrans_o != 2'b00);
            downer_d = owner_q;
            if (MAX_HOLD != 0 && owned && htrans_o[1] && hold_q != HOLD_LIM)
                hold_d = hold_q + 1'b1;
            if (rearb) begin
                if (found) begin
                    state_d = ST_OWNED;
                    owner_d = win;
                    if (!owned || win != owner_q) hold_d = '0;
                    if (ARB_MODE == 1)
                        rr_ptr_d = OW'((int'(win) + 1) % NUM_MASTERS);
                end else begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
        end
    end

    // Address-phase mux from the registered owner; zeros when idle.
    always_comb begin
        haddr_o  = '0;
        htrans_o = 2'b00;
        hwrite_o = 1'b0;
        hsize_o  = 3'b000;
        if (owned) begin
            haddr_o  = m_haddr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
            htrans_o = m_htrans_i[owner_q*2 +: 2];
            hwrite_o = m_hwrite_i[owner_q];
            hsize_o  = m_hsize_i[owner_q*3 +: 3];
        end
    end

    assign hwdata_o   = dvalid_q ? m_hwdata_i[downer_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_hrdata_o = hrdata_i;
    assign owner_o    = owner_q;

    always_comb begin
        grant_o    = '0;
        m_hready_o = '0;
        m_hresp_o  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            logic dsel;
            dsel          = dvalid_q && (downer_q == OW'(i));
            grant_o[i]    = owned && (owner_q == OW'(i));
            m_hready_o[i] = hready_i && (grant_o[i] || dsel);
            m_hresp_o[i*2 +: 2] = dsel ? hresp_i : 2'b00;
        end
    end

    assign stall_o = req_i & ~grant_o;

endmodule

// File: tb/tb_ahb_multi_master_arbiter.sv
// Directed bench: instance a = 2 masters, fixed priority, hold limit 4;
// instance b = 3 masters, round robin, unlimited hold.
module tb_ahb_multi_master_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance a ----------------
    logic [1:0]  a_req = '0, a_lock = '0, a_grant, a_stall, a_hwrite = '0, a_mhready;
    logic        a_owner;
    logic [63:0] a_haddr = '0, a_hwdata = '0;
    logic [3:0]  a_htrans = '0, a_mhresp;
    logic [5:0]  a_hsize = '0;
    logic [31:0] a_mhrdata, a_haddr_o, a_hwdata_o, a_hrdata = 32'h1234_5678;
    logic [1:0]  a_htrans_o, a_hresp = 2'b00;
    logic        a_hwrite_o, a_hready = 1'b1;
    logic [2:0]  a_hsize_o;

    ahb_multi_master_arbiter #(.NUM_MASTERS(2), .ARB_MODE(0), .MAX_HOLD(4)) u_a (
        .clk_i(clk), .resetn_i(rst_n), .req_i(a_req), .lock_i(a_lock),
        .grant_o(a_grant), .stall_o(a_stall), .owner_o(a_owner),
        .m_haddr_i(a_haddr), .m_htrans_i(a_htrans), .m_hwrite_i(a_hwrite),
        .m_hsize_i(a_hsize), .m_hwdata_i(a_hwdata), .m_hrdata_o(a_mhrdata),
        .m_hready_o(a_mhready), .m_hresp_o(a_mhresp),
        .haddr_o(a_haddr_o), .htrans_o(a_htrans_o), .hwrite_o(a_hwrite_o),
        .hsize_o(a_hsize_o), .hwdata_o(a_hwdata_o),
        .hrdata_i(a_hrdata), .hready_i(a_hready), .hresp_i(a_hresp)
    );

    // ---------------- instance b ----------------
    logic [2:0]  b_req = '0, b_lock = '0, b_grant, b_stall, b_hwrite = '0, b_mhready;
    logic [1:0]  b_owner;
    logic [95:0] b_haddr = '0, b_hwdata = '0;
    logic [5:0]  b_htrans = '0, b_mhresp;
    logic [8:0]  b_hsize = '0;
    logic [31:0] b_mhrdata, b_haddr_o, b_hwdata_o, b_hrdata = '0;
    logic [1:0]  b_htrans_o, b_hresp = 2'b00;
    logic        b_hwrite_o, b_hready = 1'b1;
    logic [2:0]  b_hsize_o;

    ahb_multi_master_arbiter #(.NUM_MASTERS(3), .ARB_MODE(1), .MAX_HOLD(0)) u_b (
        .clk_i(clk), .resetn_i(rst_n), .req_i(b_req), .lock_i(b_lock),
        .grant_o(b_grant), .stall_o(b_stall), .owner_o(b_owner),
        .m_haddr_i(b_haddr), .m_htrans_i(b_htrans), .m_hwrite_i(b_hwrite),
        .m_hsize_i(b_hsize), .m_hwdata_i(b_hwdata), .m_hrdata_o(b_mhrdata),
        .m_hready_o(b_mhready), .m_hresp_o(b_mhresp),
        .haddr_o(b_haddr_o), .htrans_o(b_htrans_o), .hwrite_o(b_hwrite_o),
        .hsize_o(b_hsize_o), .hwdata_o(b_hwdata_o),
        .hrdata_i(b_hrdata), .hready_i(b_hready), .hresp_i(b_hresp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_grant", a_grant, 2'b00);
        chk("rst_htrans", a_htrans_o, 2'b00);
        chk("rst_haddr", a_haddr_o, 32'h0);
        chk("rst_hwdata", a_hwdata_o, 32'h0);
        chk("rst_owner", a_owner, 1'b0);
        chk("rst_b_grant", b_grant, 3'b000);
        tick(); tick();
        rst_n = 1'b1;

        // 1: fixed priority, master 0 keeps bus while master 1 waits
        a_req = 2'b01;
        tick();
        chk("t1_grant0", a_grant, 2'b01);
        chk("t1_stall0", a_stall, 2'b00);
        repeat (3) tick();
        a_req = 2'b11;
        #1;
        chk("t1_stall10", a_stall, 2'b10);
        tick();
        chk("t1_keep", a_grant, 2'b01);
        a_req = 2'b10; a_hready = 1'b0;
        tick();
        chk("t1_hold_hready0", a_grant, 2'b01);
        a_hready = 1'b1;
        tick();
        chk("t1_grant1", a_grant, 2'b10);
        chk("t1_owner1", a_owner, 1'b1);
        chk("t1_stall_clr", a_stall, 2'b00);

        // 3: hold limit, then lock overrides it
        a_req = 2'b00;
        tick();
        chk("t3_idle", a_grant, 2'b00);
        a_req = 2'b01;
        tick();
        chk("t3_g0", a_grant, 2'b01);
        a_req = 2'b11; a_htrans[1:0] = 2'b10; a_haddr[31:0] = 32'h0000_0100;
        #1;
        chk("t3_htrans_mux", a_htrans_o, 2'b10);
        chk("t3_haddr_mux", a_haddr_o, 32'h100);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_beat_keep", a_grant, 2'b01);
        end
        tick();
        chk("t3_hold_move", a_grant, 2'b10);

        a_req = 2'b00; a_htrans = '0;
        tick();
        chk("t3_idle2", a_grant, 2'b00);
        a_req = 2'b01;
        tick();
        a_req = 2'b11; a_htrans[1:0] = 2'b11; a_lock = 2'b01;
        repeat (5) tick();
        chk("t3_lock_keep5", a_grant, 2'b01);
        tick();
        chk("t3_lock_keep6", a_grant, 2'b01);
        a_lock = 2'b00;
        tick();
        chk("t3_unlock_move", a_grant, 2'b10);

        // 4: handover stretched by hready_i = 0
        a_req = 2'b00; a_htrans = '0;
        tick();
        a_req = 2'b01;
        tick();
        chk("t4_g0", a_grant, 2'b01);
        a_htrans = 4'b1010; a_hwrite = 2'b11;
        a_hwdata = {32'h5A5A_0001, 32'hA5A5_A5A5};
        a_haddr  = {32'h0000_0200, 32'h0000_0100};
        a_req = 2'b10; a_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_wait", a_grant, 2'b01);
        end
        a_hready = 1'b1;
        tick();
        chk("t4_grant1", a_grant, 2'b10);
        chk("t4_hwdata_old", a_hwdata_o, 32'hA5A5_A5A5);
        chk("t4_haddr_new", a_haddr_o, 32'h200);
        chk("t4_mhready", a_mhready, 2'b11);

        // 5: error response routed to data-phase owner only
        tick();
        a_hresp = 2'b01;
        #1;
        chk("t5_hresp", a_mhresp, 4'b0100);
        chk("t5_hwdata1", a_hwdata_o, 32'h5A5A_0001);
        chk("t5_hrdata", a_mhrdata, 32'h1234_5678);
        a_hresp = 2'b00;

        // 2: round robin 0,1,2,0 with owners releasing
        b_req = 3'b111;
        tick();
        chk("t2_rr0", b_grant, 3'b001);
        b_req = 3'b110;
        tick();
        chk("t2_rr1", b_grant, 3'b010);
        b_req = 3'b101;
        tick();
        chk("t2_rr2", b_grant, 3'b100);
        b_req = 3'b011;
        tick();
        chk("t2_rr3", b_grant, 3'b001);
        chk("t2_owner", b_owner, 2'd0);

        // 6: asynchronous reset in the middle of a burst
        a_htrans[3:2] = 2'b11;
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_grant", a_grant, 2'b00);
        chk("t6_htrans", a_htrans_o, 2'b00);
        chk("t6_hwdata", a_hwdata_o, 32'h0);
        chk("t6_b_grant", b_grant, 3'b000);
        a_htrans = '0; a_req = 2'b01; a_lock = '0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_still_idle", a_grant, 2'b00);
        tick();
        chk("t6_regrant", a_grant, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
